// File: rtl/output_port_allocator_if.sv
// rtl/output_port_allocator_if.sv - request/grant bundle between input side and one output port allocator
interface output_port_allocator_if;
  logic [4:0] req_i;
  logic       credit_i;
  logic [4:0] grant_o;
  logic [2:0] mux_sel_o;
  logic [4:0] read_o;
  logic       cc_dec_o;
  logic       busy_o;
  logic [3:0] flit_cnt_o;

  modport master (
    output req_i, credit_i,
    input  grant_o, mux_sel_o, read_o, cc_dec_o, busy_o, flit_cnt_o
  );

  modport slave (
    input  req_i, credit_i,
    output grant_o, mux_sel_o, read_o, cc_dec_o, busy_o, flit_cnt_o
  );
endinterface

// File: rtl/output_port_allocator.sv
// rtl/output_port_allocator.sv - round-robin wormhole allocator locking one output port per packet
module output_port_allocator #(
  parameter int         NUM_PORTS = 5,
  parameter int         PKT_LEN   = 4,
  parameter logic [4:0] PORT_MASK = 5'b11111,
  parameter logic [2:0] SEL_IDLE  = 3'd7
) (
  input logic                    clk,
  input logic                    reset,
  output_port_allocator_if.slave bus
);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t     r_state, w_state_nxt;
  logic [4:0] r_grant, w_grant_nxt;
  logic [2:0] r_owner, w_owner_nxt;
  logic [2:0] r_mux_sel, w_mux_sel_nxt;
  logic [2:0] r_rr_ptr, w_rr_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  logic [4:0] w_eff_req;
  logic [2:0] w_ptr;
  logic [2:0] w_idx;
  logic [2:0] w_win;
  logic       w_found;
  logic       w_xfer;
  logic       w_last;

  assign w_eff_req = bus.req_i & PORT_MASK;
  assign w_ptr     = (r_rr_ptr > 3'd4) ? 3'd4 : r_rr_ptr;

  // Search starts one past the last owner and wraps, so the last owner has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    w_idx   = 3'd0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      w_idx = 3'((int'(w_ptr) + i) % NUM_PORTS);
      if (!w_found && w_eff_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_xfer = (r_state == S_LOCKED) && bus.req_i[r_owner] && bus.credit_i;
  assign w_last = w_xfer && (r_cnt == 4'(PKT_LEN - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_owner_nxt   = r_owner;
    w_mux_sel_nxt = r_mux_sel;
    w_rr_nxt      = r_rr_ptr;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt   = S_LOCKED;
          w_grant_nxt   = 5'b00001 << w_win;
          w_owner_nxt   = w_win;
          w_mux_sel_nxt = w_win;
          w_cnt_nxt     = 4'd0;
        end
      end
      S_LOCKED: begin
        if (w_last) begin
          w_state_nxt   = S_IDLE;
          w_grant_nxt   = 5'b00000;
          w_mux_sel_nxt = SEL_IDLE;
          w_cnt_nxt     = 4'd0;
          w_rr_nxt      = r_owner;
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_grant   <= 5'b00000;
      r_owner   <= 3'd0;
      r_mux_sel <= SEL_IDLE;
      r_rr_ptr  <= 3'd4;
      r_cnt     <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_owner   <= w_owner_nxt;
      r_mux_sel <= w_mux_sel_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign bus.grant_o    = r_grant;
  assign bus.mux_sel_o  = r_mux_sel;
  assign bus.read_o     = w_xfer ? r_grant : 5'b00000;
  assign bus.cc_dec_o   = w_xfer;
  assign bus.busy_o     = (r_state == S_LOCKED);
  assign bus.flit_cnt_o = r_cnt;

endmodule

// File: tb/tb_output_port_allocator.sv
// tb/tb_output_port_allocator.sv - directed bench for output_port_allocator
module tb_output_port_allocator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  output_port_allocator_if u_if ();
  output_port_allocator_if u_if2 ();

  output_port_allocator u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  output_port_allocator #(
    .PKT_LEN   (1),
    .PORT_MASK (5'b11011)
  ) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if2)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Packed view: {grant, read, cc_dec, busy, flit_cnt, mux_sel}
  function automatic logic [2:0] sel_of(input logic [4:0] g);
    case (g)
      5'b00001: return 3'd0;
      5'b00010: return 3'd1;
      5'b00100: return 3'd2;
      5'b01000: return 3'd3;
      5'b10000: return 3'd4;
      default:  return 3'd7;
    endcase
  endfunction

  function automatic logic [18:0] exp_vec(input logic [4:0] g, input logic [4:0] r, input logic [3:0] c);
    return {g, r, |r, |g, c, sel_of(g)};
  endfunction

  function automatic logic [18:0] act1();
    return {u_if.grant_o, u_if.read_o, u_if.cc_dec_o, u_if.busy_o, u_if.flit_cnt_o, u_if.mux_sel_o};
  endfunction

  function automatic logic [18:0] act2();
    return {u_if2.grant_o, u_if2.read_o, u_if2.cc_dec_o, u_if2.busy_o, u_if2.flit_cnt_o, u_if2.mux_sel_o};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset          = 1'b1;
    u_if.req_i     = 5'b0;
    u_if.credit_i  = 1'b0;
    u_if2.req_i    = 5'b0;
    u_if2.credit_i = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    logic [18:0] e;
    do_reset();
    #2;
    e = exp_vec(5'b0, 5'b0, 4'd0);
    if (act1() !== e) begin
      $display("FAIL reset_dut1: got %b expected %b", act1(), e);
      n_err++;
    end
    n_cmp++;
    if (act2() !== e) begin
      $display("FAIL reset_dut2: got %b expected %b", act2(), e);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_single_l;
    logic [4:0]  g_t [7] = '{5'b0, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b0, 5'b10000};
    logic [4:0]  r_t [7] = '{5'b0, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b0, 5'b10000};
    logic [3:0]  c_t [7] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0};
    logic [18:0] e;
    do_reset();
    u_if.req_i    = 5'b10000;
    u_if.credit_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #2;
      e = exp_vec(g_t[c], r_t[c], c_t[c]);
      if (act1() !== e) begin
        $display("FAIL single_l cyc%0d: got %b expected %b", c, act1(), e);
        n_err++;
      end
      n_cmp++;
      tick();
    end
  endtask

  task automatic test_round_robin;
    logic [4:0]  own;
    logic [18:0] e;
    do_reset();
    u_if.req_i    = 5'b01001;
    u_if.credit_i = 1'b1;
    for (int p = 0; p < 4; p++) begin
      own = (p % 2 == 0) ? 5'b00001 : 5'b01000;
      for (int c = 0; c < 5; c++) begin
        #2;
        e = (c == 0) ? exp_vec(5'b0, 5'b0, 4'd0) : exp_vec(own, own, 4'(c - 1));
        if (act1() !== e) begin
          $display("FAIL round_robin pkt%0d cyc%0d: got %b expected %b", p, c, act1(), e);
          n_err++;
        end
        n_cmp++;
        tick();
      end
    end
  endtask

  task automatic test_credit_stall;
    logic        cr_t [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0]  g_t  [9] = '{5'b0, 5'b1, 5'b1, 5'b1, 5'b1, 5'b1, 5'b1, 5'b1, 5'b0};
    logic [4:0]  r_t  [9] = '{5'b0, 5'b1, 5'b1, 5'b0, 5'b0, 5'b0, 5'b1, 5'b1, 5'b0};
    logic [3:0]  c_t  [9] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd0};
    logic [18:0] e;
    int          reads = 0;
    do_reset();
    u_if.req_i = 5'b00001;
    for (int c = 0; c < 9; c++) begin
      u_if.credit_i = cr_t[c];
      #2;
      e = exp_vec(g_t[c], r_t[c], c_t[c]);
      if (act1() !== e) begin
        $display("FAIL credit_stall cyc%0d: got %b expected %b", c, act1(), e);
        n_err++;
      end
      n_cmp++;
      if (u_if.read_o[0]) reads++;
      tick();
    end
    if (reads !== 4) begin
      $display("FAIL credit_stall_reads: got %0d expected 4", reads);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_owner_drop;
    logic [4:0]  q_t [9] = '{5'b00010, 5'b10010, 5'b10010, 5'b10000, 5'b10000, 5'b10010, 5'b10010, 5'b10010, 5'b10010};
    logic [4:0]  g_t [9] = '{5'b0, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b0, 5'b10000};
    logic [4:0]  r_t [9] = '{5'b0, 5'b00010, 5'b00010, 5'b0, 5'b0, 5'b00010, 5'b00010, 5'b0, 5'b10000};
    logic [3:0]  c_t [9] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd0, 4'd0};
    logic [18:0] e;
    do_reset();
    u_if.credit_i = 1'b1;
    for (int c = 0; c < 9; c++) begin
      u_if.req_i = q_t[c];
      #2;
      e = exp_vec(g_t[c], r_t[c], c_t[c]);
      if (act1() !== e) begin
        $display("FAIL owner_drop cyc%0d: got %b expected %b", c, act1(), e);
        n_err++;
      end
      n_cmp++;
      tick();
    end
  endtask

  task automatic test_port_mask;
    logic [4:0]  g_t [4] = '{5'b0, 5'b00001, 5'b0, 5'b00001};
    logic [18:0] e;
    do_reset();
    u_if2.req_i    = 5'b00100;
    u_if2.credit_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #2;
      e = exp_vec(5'b0, 5'b0, 4'd0);
      if (act2() !== e) begin
        $display("FAIL port_mask_idle cyc%0d: got %b expected %b", c, act2(), e);
        n_err++;
      end
      n_cmp++;
      tick();
    end
    u_if2.req_i = 5'b00101;
    for (int c = 0; c < 4; c++) begin
      #2;
      e = exp_vec(g_t[c], g_t[c], 4'd0);
      if (act2() !== e) begin
        $display("FAIL port_mask_n cyc%0d: got %b expected %b", c, act2(), e);
        n_err++;
      end
      n_cmp++;
      tick();
    end
  endtask

  task automatic test_async_reset;
    logic [18:0] e;
    int          reads = 0;
    do_reset();
    u_if.req_i    = 5'b01000;
    u_if.credit_i = 1'b1;
    tick();
    tick();
    tick();
    #2;
    e = exp_vec(5'b01000, 5'b01000, 4'd2);
    if (act1() !== e) begin
      $display("FAIL async_pre: got %b expected %b", act1(), e);
      n_err++;
    end
    n_cmp++;
    reset = 1'b1;
    #1;
    e = exp_vec(5'b0, 5'b0, 4'd0);
    if (act1() !== e) begin
      $display("FAIL async_mid: got %b expected %b", act1(), e);
      n_err++;
    end
    n_cmp++;
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #2;
      e = (c == 0 || c == 5) ? exp_vec(5'b0, 5'b0, 4'd0) : exp_vec(5'b01000, 5'b01000, 4'(c - 1));
      if (act1() !== e) begin
        $display("FAIL async_fresh cyc%0d: got %b expected %b", c, act1(), e);
        n_err++;
      end
      n_cmp++;
      if (u_if.read_o[3]) reads++;
      tick();
    end
    if (reads !== 4) begin
      $display("FAIL async_fresh_reads: got %0d expected 4", reads);
      n_err++;
    end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_single_l();
    test_round_robin();
    test_credit_stall();
    test_owner_drop();
    test_port_mask();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
